clkdiv_prog: RTL and testbench

- Runtime-programmable clock divider, the next generation of the fixed F0/F1 divider.
- Generates a divided square wave with programmable duty cycle, plus a one-cycle period tick (clock-enable strobe).
- Divisor and high time can be reconfigured through a valid/ready handshake. The change takes effect glitch-free at the next period boundary.
- Drives slow peripherals (UART baud, LED scan, 7-seg mux) from the single system clock. All outputs are data, not a derived clock net.

---
 rtl/clkdiv_prog.sv | 115 +++++++++++
 tb/tb_clkdiv_prog.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/clkdiv_prog.sv
// clkdiv_prog: runtime-programmable clock divider.
//
// Produces a divided square wave with programmable high time, and a one-cycle
// tick on the last cycle of each period. Both are registered data outputs
// meant for use as clock enables, not as clock nets. A new divisor/high-time
// pair is accepted through a valid/ready handshake into a one-deep pending
// slot. It takes effect at the next period boundary, or immediately while
// the divider is stopped.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   en         run enable; 0 holds the counter at phase 0 with outputs low
//   cfg_valid  new configuration offered
//   cfg_ready  pending slot is empty and can accept a configuration
//   cfg_div    new period in clk cycles (0 is treated as 1)
//   cfg_high   new high time in clk cycles (>= period gives constant 1)
//   out        divided waveform
//   tick       one-cycle pulse on the last cycle of each period
//   phase      current counter value
module clkdiv_prog #(
  parameter int unsigned F0 = 50_000_000,
  parameter int unsigned F1 = 12_500_000,
  parameter int unsigned W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_div,
  input  logic [W-1:0] cfg_high,
  output logic         out,
  output logic         tick,
  output logic [W-1:0] phase
);

  localparam int unsigned    DEF_DIV_I = F0 / F1;
  localparam logic [W-1:0]   DEF_DIV   = W'(DEF_DIV_I);
  localparam logic [W-1:0]   DEF_HIGH  = W'(DEF_DIV_I / 2);

  // A zero period has no meaning; it is stored as the shortest legal period.
  function automatic logic [W-1:0] clamp_div(input logic [W-1:0] d);
    return (d == '0) ? W'(1) : d;
  endfunction

  logic [W-1:0] act_div, act_high;
  logic         pend_valid;
  logic [W-1:0] pend_div, pend_high;

  logic [W-1:0] cnt_p0;
  logic         out_p1, tick_p1;

  logic         xfer;
  logic         last_p0;

  assign cfg_ready = !pend_valid;
  assign xfer      = cfg_valid && cfg_ready;
  // act_div is never 0, so act_div-1 cannot wrap.
  assign last_p0   = (cnt_p0 == act_div - W'(1));

  // Stage p0: period counter, configuration slots.
  // Stage p1: waveform and tick registered from the p0 count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0     <= '0;
      out_p1     <= 1'b0;
      tick_p1    <= 1'b0;
      pend_valid <= 1'b0;
      pend_div   <= DEF_DIV;
      pend_high  <= DEF_HIGH;
      act_div    <= DEF_DIV;
      act_high   <= DEF_HIGH;
    end else begin
      if (!en) begin
        cnt_p0  <= '0;
        out_p1  <= 1'b0;
        tick_p1 <= 1'b0;
        // Stopped: nothing is being generated, so a pending setting can be
        // taken over without waiting for a boundary.
        if (pend_valid) begin
          act_div    <= pend_div;
          act_high   <= pend_high;
          pend_valid <= 1'b0;
        end
      end else begin
        out_p1  <= (cnt_p0 < act_high);
        tick_p1 <= last_p0;
        if (last_p0) begin
          cnt_p0 <= '0;
          if (pend_valid) begin
            act_div    <= pend_div;
            act_high   <= pend_high;
            pend_valid <= 1'b0;
          end
        end else begin
          cnt_p0 <= cnt_p0 + W'(1);
        end
      end
      // A transfer only happens with the slot empty, so it never collides
      // with the slot being applied on the same edge; a transfer on a
      // boundary edge therefore waits for the following boundary.
      if (xfer) begin
        pend_valid <= 1'b1;
        pend_div   <= clamp_div(cfg_div);
        pend_high  <= cfg_high;
      end
    end
  end

  assign out   = out_p1;
  assign tick  = tick_p1;
  assign phase = cnt_p0;

endmodule

// File: tb/tb_clkdiv_prog.sv
module tb_clkdiv_prog;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         en;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_div;
  logic [W-1:0] cfg_high;
  logic         out;
  logic         tick;
  logic [W-1:0] phase;

  int total;
  int bad;

  clkdiv_prog #(.F0(50_000_000), .F1(12_500_000), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .out       (out),
    .tick      (tick),
    .phase     (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock per character; each string gives the expected out, tick and
  // phase digit seen after that clock edge.
  task automatic run(input string tag, input string o, input string t, input string p);
    for (int i = 0; i < o.len(); i++) begin
      edge_step();
      chk($sformatf("%s.out[%0d]", tag, i),   {31'd0, out},  32'(o[i] - 8'd48));
      chk($sformatf("%s.tick[%0d]", tag, i),  {31'd0, tick}, 32'(t[i] - 8'd48));
      chk($sformatf("%s.phase[%0d]", tag, i), 32'(phase),    32'(p[i] - 8'd48));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_high = '0;

    // Reset and defaults (period 4, high 2)
    repeat (3) edge_step();
    chk("rst.out",   {31'd0, out},       32'd0);
    chk("rst.tick",  {31'd0, tick},      32'd0);
    chk("rst.phase", 32'(phase),         32'd0);
    chk("rst.ready", {31'd0, cfg_ready}, 32'd1);
    rst = 1'b0; en = 1'b1;
    run("dflt", "11001100", "00010001", "12301230");

    // Reprogram mid-period at phase 1: div=6 high=1
    edge_step();
    chk("mid.phase", 32'(phase), 32'd1);
    cfg_valid = 1'b1; cfg_div = 16'd6; cfg_high = 16'd1;
    edge_step();
    cfg_valid = 1'b0;
    chk("mid.ready0", {31'd0, cfg_ready}, 32'd0);
    chk("mid.out",    {31'd0, out},       32'd1);
    run("mid.tail", "00", "01", "30");
    chk("mid.ready1", {31'd0, cfg_ready}, 32'd1);
    run("div6", "100000100000", "000001000001", "123450123450");

    // Back-to-back: A offered on the boundary edge, B held behind it
    run("b2b.pre", "10000", "00000", "12345");
    cfg_valid = 1'b1; cfg_div = 16'd3; cfg_high = 16'd2;
    edge_step();
    chk("b2b.ready0", {31'd0, cfg_ready}, 32'd0);
    chk("b2b.tick",   {31'd0, tick},      32'd1);
    cfg_div = 16'd2; cfg_high = 16'd1;
    run("b2b.hold", "100000", "000001", "123450");
    chk("b2b.readyA", {31'd0, cfg_ready}, 32'd1);
    edge_step();
    cfg_valid = 1'b0;
    chk("b2b.readyB", {31'd0, cfg_ready}, 32'd0);
    chk("b2b.outA",   {31'd0, out},       32'd1);
    chk("b2b.phA",    32'(phase),         32'd1);
    run("b2b.A", "10", "01", "20");
    chk("b2b.ready1", {31'd0, cfg_ready}, 32'd1);
    run("b2b.B", "1010", "0101", "1010");

    // Degenerate: div=0 (-> 1), high=0
    cfg_valid = 1'b1; cfg_div = 16'd0; cfg_high = 16'd0;
    edge_step();
    cfg_valid = 1'b0;
    chk("dz.ready0", {31'd0, cfg_ready}, 32'd0);
    chk("dz.phase",  32'(phase),         32'd1);
    edge_step();
    chk("dz.out",    {31'd0, out},       32'd0);
    chk("dz.tick",   {31'd0, tick},      32'd1);
    chk("dz.ready1", {31'd0, cfg_ready}, 32'd1);
    run("div1", "000", "111", "000");

    // Degenerate: div=3 high=5 -> constant high
    cfg_valid = 1'b1; cfg_div = 16'd3; cfg_high = 16'd5;
    edge_step();
    cfg_valid = 1'b0;
    chk("hg.ready0", {31'd0, cfg_ready}, 32'd0);
    chk("hg.tick0",  {31'd0, tick},      32'd1);
    edge_step();
    chk("hg.ready1", {31'd0, cfg_ready}, 32'd1);
    chk("hg.tick1",  {31'd0, tick},      32'd1);
    run("hi_ge_div", "111111", "001001", "120120");

    // Enable control: drop en at phase 2 with div=5 high=2 pending
    cfg_valid = 1'b1; cfg_div = 16'd5; cfg_high = 16'd2;
    edge_step();
    cfg_valid = 1'b0;
    chk("en.ready0", {31'd0, cfg_ready}, 32'd0);
    edge_step();
    chk("en.phase2", 32'(phase), 32'd2);
    en = 1'b0;
    edge_step();
    chk("en.out",    {31'd0, out},       32'd0);
    chk("en.tick",   {31'd0, tick},      32'd0);
    chk("en.phase",  32'(phase),         32'd0);
    chk("en.ready1", {31'd0, cfg_ready}, 32'd1);
    edge_step();
    chk("en.hold",   {31'd0, out},       32'd0);
    en = 1'b1;
    run("en.re", "11000", "00001", "12340");

    // Reset mid-period with div=7 high=3 pending
    cfg_valid = 1'b1; cfg_div = 16'd7; cfg_high = 16'd3;
    edge_step();
    cfg_valid = 1'b0;
    chk("mr.ready0", {31'd0, cfg_ready}, 32'd0);
    edge_step();
    rst = 1'b1;
    edge_step();
    rst = 1'b0;
    chk("mr.out",    {31'd0, out},       32'd0);
    chk("mr.tick",   {31'd0, tick},      32'd0);
    chk("mr.phase",  32'(phase),         32'd0);
    chk("mr.ready1", {31'd0, cfg_ready}, 32'd1);
    run("post_rst", "11001100", "00010001", "12301230");
    chk("mr.ready2", {31'd0, cfg_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
